sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async 256Kx16 SRAM between the DRAM-emulation and Pi ports via toggle req/ack.
// Latency ACCESS_CYCLES+3 clk200 cycles from idle; requesters hold fields until ack toggles. Macro SRAM_ARB_FAIR_EN selects round-robin grant.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        clk200,
  input  logic        reset,
  input  logic        dram_req,
  output logic        dram_ack,
  input  logic        dram_read,
  input  logic        dram_lb,
  input  logic        dram_ub,
  input  logic [17:0] dram_address,
  input  logic [15:0] dram_wdata,
  output logic [15:0] dram_rdata,
  input  logic        pi_req,
  output logic        pi_ack,
  input  logic        pi_read,
  input  logic        pi_lb,
  input  logic        pi_ub,
  input  logic [17:0] pi_address,
  input  logic [15:0] pi_wdata,
  output logic [15:0] pi_rdata,
  output logic [17:0] SRAM_A,
  inout  wire  [15:0] SRAM_D,
  output logic        SRAM_CE_n,
  output logic        SRAM_OE_n,
  output logic        SRAM_WE_n,
  output logic        SRAM_LB_n,
  output logic        SRAM_UB_n
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          sel_pi;
  logic          read_q, lb_q, ub_q;
  logic [17:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          d_oe;

  logic          dram_pend, pi_pend;
  logic          grant, grant_pi;
  logic          read_next, lb_next, ub_next;
  logic [17:0]   addr_next;
  logic [15:0]   wdata_next;
  logic          active_next;
  logic          ce_n_next, oe_n_next, we_n_next, lb_n_next, ub_n_next, d_oe_next;

  assign dram_pend = dram_req != dram_ack;
  assign pi_pend   = pi_req != pi_ack;

`ifdef SRAM_ARB_FAIR_EN
  logic last_pi;
  // On contention the port that was not served most recently wins.
  assign grant_pi = pi_pend && (!dram_pend || !last_pi);
`else
  assign grant_pi = pi_pend && !dram_pend;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (dram_pend || pi_pend) begin
          grant      = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
        cnt_next   = CW'(ACCESS_CYCLES - 1);
      end
      ACCESS: begin
        if (cnt == '0) state_next = HOLD;
        else           cnt_next   = cnt - CW'(1);
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_next  = read_q;
    lb_next    = lb_q;
    ub_next    = ub_q;
    addr_next  = addr_q;
    wdata_next = wdata_q;
    if (grant) begin
      if (grant_pi) begin
        read_next  = pi_read;
        lb_next    = pi_lb;
        ub_next    = pi_ub;
        addr_next  = pi_address;
        wdata_next = pi_wdata;
      end else begin
        read_next  = dram_read;
        lb_next    = dram_lb;
        ub_next    = dram_ub;
        addr_next  = dram_address;
        wdata_next = dram_wdata;
      end
    end
  end

  // SRAM controls are decoded from the next state and registered so strobes never glitch.
  always_comb begin
    active_next = state_next != IDLE;
    ce_n_next   = !active_next;
    oe_n_next   = !((state_next == ACCESS) && read_next);
    we_n_next   = !((state_next == ACCESS) && !read_next);
    lb_n_next   = !(active_next && lb_next);
    ub_n_next   = !(active_next && ub_next);
    d_oe_next   = active_next && !read_next;
  end

  always_ff @(posedge clk200) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_pi     <= 1'b0;
      read_q     <= 1'b0;
      lb_q       <= 1'b0;
      ub_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dram_ack   <= 1'b0;
      pi_ack     <= 1'b0;
      dram_rdata <= '0;
      pi_rdata   <= '0;
      SRAM_CE_n  <= 1'b1;
      SRAM_OE_n  <= 1'b1;
      SRAM_WE_n  <= 1'b1;
      SRAM_LB_n  <= 1'b1;
      SRAM_UB_n  <= 1'b1;
      d_oe       <= 1'b0;
`ifdef SRAM_ARB_FAIR_EN
      last_pi    <= 1'b1;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      read_q    <= read_next;
      lb_q      <= lb_next;
      ub_q      <= ub_next;
      addr_q    <= addr_next;
      wdata_q   <= wdata_next;
      SRAM_CE_n <= ce_n_next;
      SRAM_OE_n <= oe_n_next;
      SRAM_WE_n <= we_n_next;
      SRAM_LB_n <= lb_n_next;
      SRAM_UB_n <= ub_n_next;
      d_oe      <= d_oe_next;
      if (grant) sel_pi <= grant_pi;
      // OE_n is still low on this edge, so the bus carries valid read data.
      if ((state == ACCESS) && (cnt == '0) && read_q) begin
        if (sel_pi) pi_rdata   <= SRAM_D;
        else        dram_rdata <= SRAM_D;
      end
      if (state == HOLD) begin
        if (sel_pi) pi_ack   <= !pi_ack;
        else        dram_ack <= !dram_ack;
`ifdef SRAM_ARB_FAIR_EN
        last_pi <= sel_pi;
`endif
      end
    end
  end

  assign SRAM_A = addr_q;
  assign SRAM_D = d_oe ? wdata_q : 16'bz;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors against an SRAM model, a transaction-level reference model
// compared every cycle, and hand-computed literal expectations.
`timescale 1ns/100ps
module tb_sram_arbiter;
  localparam int A = 3;
`ifdef SRAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk200, reset;
  logic        dram_req, dram_read, dram_lb, dram_ub;
  logic [17:0] dram_address;
  logic [15:0] dram_wdata;
  logic        pi_req, pi_read, pi_lb, pi_ub;
  logic [17:0] pi_address;
  logic [15:0] pi_wdata;
  logic        dram_ack, pi_ack;
  logic [15:0] dram_rdata, pi_rdata;
  logic [17:0] sram_a;
  wire  [15:0] sram_d;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  sram_arbiter #(.ACCESS_CYCLES(A)) dut (
    .clk200(clk200), .reset(reset),
    .dram_req(dram_req), .dram_ack(dram_ack), .dram_read(dram_read),
    .dram_lb(dram_lb), .dram_ub(dram_ub), .dram_address(dram_address),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .pi_req(pi_req), .pi_ack(pi_ack), .pi_read(pi_read),
    .pi_lb(pi_lb), .pi_ub(pi_ub), .pi_address(pi_address),
    .pi_wdata(pi_wdata), .pi_rdata(pi_rdata),
    .SRAM_A(sram_a), .SRAM_D(sram_d), .SRAM_CE_n(sram_ce_n), .SRAM_OE_n(sram_oe_n),
    .SRAM_WE_n(sram_we_n), .SRAM_LB_n(sram_lb_n), .SRAM_UB_n(sram_ub_n)
  );

  initial clk200 = 1'b0;
  always #2.5 clk200 = ~clk200;

  // SRAM model; drives 0 while deselected so any stray arbiter drive corrupts the idle value.
  logic [15:0] mem     [0:262143];
  logic [15:0] ref_mem [0:262143];
  wire sram_rd = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_d = sram_rd ? mem[sram_a] : (sram_ce_n ? 16'h0000 : 16'hzzzz);

  always @(negedge clk200) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_a][7:0]  = sram_d[7:0];
      if (!sram_ub_n) mem[sram_a][15:8] = sram_d[15:8];
    end
  end

  int vectors = 0, errs = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked by cycles elapsed since grant.
  bit          busy;
  int          phase, cport, last;
  logic        cread, clb, cub;
  logic [17:0] caddr, m_addr;
  logic [15:0] cwd;
  logic        m_ack   [2];
  logic [15:0] m_rdata [2];
  logic [15:0] m_rmask [2];

  always @(posedge clk200) begin
    if (reset) begin
      busy = 1'b0; phase = 0; last = 1; m_addr = '0;
      for (int p = 0; p < 2; p++) begin
        m_ack[p] = 1'b0; m_rdata[p] = '0; m_rmask[p] = 16'hFFFF;
      end
    end else if (busy) begin
      phase++;
      if (phase == A + 1 && cread) begin
        m_rdata[cport] = ref_mem[caddr];
        m_rmask[cport] = {{8{cub}}, {8{clb}}};
      end else if (phase == A + 2) begin
        if (!cread) begin
          if (clb) ref_mem[caddr][7:0]  = cwd[7:0];
          if (cub) ref_mem[caddr][15:8] = cwd[15:8];
        end
        m_ack[cport] = !m_ack[cport];
        last = cport;
        busy = 1'b0;
      end
    end else begin
      bit pd, pp;
      pd = dram_req != m_ack[0];
      pp = pi_req != m_ack[1];
      if (pd || pp) begin
        if (pd && pp) cport = FAIR ? (last == 0 ? 1 : 0) : 0;
        else          cport = pp ? 1 : 0;
        if (cport == 0) begin
          cread = dram_read; clb = dram_lb; cub = dram_ub; caddr = dram_address; cwd = dram_wdata;
        end else begin
          cread = pi_read; clb = pi_lb; cub = pi_ub; caddr = pi_address; cwd = pi_wdata;
        end
        m_addr = caddr;
        busy = 1'b1;
        phase = 0;
      end
    end
  end

  always @(negedge clk200) begin
    if (chk_en) begin
      bit acc;
      acc = busy && phase >= 1 && phase <= A;
      chk("ce_n", sram_ce_n, !busy);
      chk("oe_n", sram_oe_n, !(acc && cread));
      chk("we_n", sram_we_n, !(acc && !cread));
      chk("lb_n", sram_lb_n, !(busy && clb));
      chk("ub_n", sram_ub_n, !(busy && cub));
      chk("sram_a", sram_a, m_addr);
      if (busy && !cread) chk("sram_d write", sram_d, cwd);
      else if (!busy)     chk("sram_d idle", sram_d, 16'h0000);
      chk("dram_ack", dram_ack, m_ack[0]);
      chk("pi_ack", pi_ack, m_ack[1]);
      chk("dram_rdata", dram_rdata & m_rmask[0], m_rdata[0] & m_rmask[0]);
      chk("pi_rdata", pi_rdata & m_rmask[1], m_rdata[1] & m_rmask[1]);
    end
  end

  int oe_lo, we_lo, lb_lo, ub_lo, dval;
  logic [15:0] watch;

  task automatic start(input int port, input logic rd, input logic [17:0] a,
                       input logic lb, input logic ub, input logic [15:0] wd);
    if (port == 0) begin
      dram_read = rd; dram_address = a; dram_lb = lb; dram_ub = ub; dram_wdata = wd;
      dram_req = !dram_req;
    end else begin
      pi_read = rd; pi_address = a; pi_lb = lb; pi_ub = ub; pi_wdata = wd;
      pi_req = !pi_req;
    end
  endtask

  task automatic wait_ack(input int port, input int exp_n, input string nm);
    logic a0;
    int n;
    bit seen;
    a0 = (port == 0) ? dram_ack : pi_ack;
    n = 0; seen = 1'b0;
    oe_lo = 0; we_lo = 0; lb_lo = 0; ub_lo = 0; dval = 0;
    while (!seen && n < 40) begin
      @(negedge clk200);
      n++;
      oe_lo += int'(!sram_oe_n);
      we_lo += int'(!sram_we_n);
      lb_lo += int'(!sram_lb_n);
      ub_lo += int'(!sram_ub_n);
      dval  += int'(!sram_ce_n && (sram_d === watch));
      if (((port == 0) ? dram_ack : pi_ack) != a0) seen = 1'b1;
    end
    chk(nm, n, exp_n);
  endtask

  task automatic t_simul();
    logic a0, a1;
    int nd, np;
    a0 = dram_ack; a1 = pi_ack; nd = 0; np = 0;
    start(0, 1'b1, 18'h00020, 1'b1, 1'b1, 16'h0);
    start(1, 1'b1, 18'h12345, 1'b1, 1'b1, 16'h0);
    for (int n = 1; n <= 40 && (nd == 0 || np == 0); n++) begin
      @(negedge clk200);
      if (nd == 0 && dram_ack != a0) nd = n;
      if (np == 0 && pi_ack != a1)   np = n;
    end
    chk("simul dram latency", nd, FAIR ? 12 : 6);
    chk("simul pi latency", np, FAIR ? 6 : 12);
    chk("simul dram_rdata", dram_rdata, 16'h2222);
    chk("simul pi_rdata", pi_rdata, 16'hBEEF);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 262144; i++) mem[i] = 16'(i);
    mem[18'h12345] = 16'hBEEF;
    mem[18'h00000] = 16'h0F0F;
    mem[18'h3FFFF] = 16'hF00D;
    mem[18'h00010] = 16'h1234;
    mem[18'h00020] = 16'h2222;
    mem[18'h00040] = 16'h4444;
    for (int i = 0; i < 262144; i++) ref_mem[i] = mem[i];
    watch = 16'h0;
    reset = 1'b1;
    dram_req = 0; dram_read = 1; dram_lb = 1; dram_ub = 1; dram_address = '0; dram_wdata = '0;
    pi_req = 0; pi_read = 1; pi_lb = 1; pi_ub = 1; pi_address = '0; pi_wdata = '0;
    repeat (3) @(negedge clk200);
    chk_en = 1'b1;
    chk("rst ce_n", sram_ce_n, 1'b1);
    chk("rst we_n", sram_we_n, 1'b1);
    chk("rst sram_a", sram_a, 18'h0);
    chk("rst dram_rdata", dram_rdata, 16'h0);
    reset = 1'b0;
    @(negedge clk200);

    // Reset aborts a write in ACCESS; the still-pending request then completes.
    start(1, 1'b0, 18'h00030, 1'b1, 1'b1, 16'h1111);
    n = 0;
    while (sram_we_n && n < 20) begin @(negedge clk200); n++; end
    chk("reach write access", sram_we_n, 1'b0);
    reset = 1'b1;
    @(negedge clk200);
    chk("abort we_n", sram_we_n, 1'b1);
    chk("abort sram_d", sram_d, 16'h0000);
    chk("abort pi_ack", pi_ack, 1'b0);
    reset = 1'b0;
    wait_ack(1, 6, "retry pi latency");
    chk("retry mem", mem[18'h00030], 16'h1111);

    start(0, 1'b1, 18'h12345, 1'b1, 1'b1, 16'h0);
    wait_ack(0, 6, "dram read latency");
    chk("dram read oe cycles", oe_lo, 3);
    chk("dram read data", dram_rdata, 16'hBEEF);
    chk("dram ack value", dram_ack, 1'b1);

    t_simul();

    watch = 16'hA55A;
    start(1, 1'b0, 18'h00010, 1'b1, 1'b0, 16'hA55A);
    wait_ack(1, 6, "pi write latency");
    chk("pi write we cycles", we_lo, 3);
    chk("pi write lb cycles", lb_lo, 5);
    chk("pi write ub cycles", ub_lo, 0);
    chk("pi write data cycles", dval, 5);
    chk("pi write bus released", sram_d, 16'h0000);
    chk("pi write mem", mem[18'h00010], 16'h125A);

    start(1, 1'b1, 18'h00010, 1'b1, 1'b1, 16'h0);
    wait_ack(1, 6, "pi read latency");
    chk("pi readback", pi_rdata, 16'h125A);

    start(0, 1'b1, 18'h00000, 1'b1, 1'b1, 16'h0);
    wait_ack(0, 6, "b2b first latency");
    chk("b2b first data", dram_rdata, 16'h0F0F);
    chk("b2b idle gap", sram_ce_n, 1'b1);
    start(0, 1'b1, 18'h3FFFF, 1'b1, 1'b1, 16'h0);
    wait_ack(0, 6, "b2b second latency");
    chk("b2b second data", dram_rdata, 16'hF00D);

    start(0, 1'b0, 18'h00040, 1'b0, 1'b0, 16'hFFFF);
    wait_ack(0, 6, "nolane latency");
    chk("nolane lb cycles", lb_lo, 0);
    chk("nolane ub cycles", ub_lo, 0);
    chk("nolane mem", mem[18'h00040], 16'h4444);

    repeat (3) @(negedge clk200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
